// File: rtl/affine_luma_interp_6tap.sv
// 6-tap luma interpolation filter (1/16-pel) for affine motion compensation.
// Three-stage pipeline: shift-add tap products, two partial sums, final sum with optional rounding shift.
module affine_luma_interp_6tap #(
  parameter int SAMPLE_W = 8,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_frac,
  input  logic [6*SAMPLE_W-1:0]      in_samples,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    out_data
);

  localparam int ACC_W = OUT_W + 2;

  // Half-pel-and-below table; positions above 8 reuse it mirrored.
  function automatic int coef_base(input int p, input int k);
    int c [6];
    case (p)
      0:       c = '{0,   0, 64,  0,   0, 0};
      1:       c = '{1,  -3, 63,  4,  -2, 1};
      2:       c = '{1,  -5, 62,  8,  -3, 1};
      3:       c = '{2,  -8, 60, 13,  -4, 1};
      4:       c = '{3, -10, 58, 17,  -5, 1};
      5:       c = '{3, -11, 52, 26,  -8, 2};
      6:       c = '{2,  -9, 47, 31, -10, 3};
      7:       c = '{3, -11, 45, 34, -10, 3};
      default: c = '{3, -11, 40, 40, -11, 3};
    endcase
    return c[k[2:0]];
  endfunction

  function automatic int coef_of(input logic [3:0] p, input int k);
    if (p <= 4'd8) return coef_base(int'(p), k);
    return coef_base(16 - int'(p), 5 - k);
  endfunction

  // Constant multiply expressed purely as shifts and adds of the zero-extended sample.
  function automatic logic signed [ACC_W-1:0] mcm(input logic [SAMPLE_W-1:0] s, input int c);
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] r;
    int m;
    x = $signed({{(ACC_W-SAMPLE_W){1'b0}}, s});
    m = (c < 0) ? -c : c;
    case (m)
      1:       r = x;
      2:       r = x << 1;
      3:       r = (x << 1) + x;
      4:       r = x << 2;
      5:       r = (x << 2) + x;
      8:       r = x << 3;
      9:       r = (x << 3) + x;
      10:      r = (x << 3) + (x << 1);
      11:      r = (x << 3) + (x << 1) + x;
      13:      r = (x << 3) + (x << 2) + x;
      17:      r = (x << 4) + x;
      26:      r = (x << 4) + (x << 3) + (x << 1);
      31:      r = (x << 5) - x;
      34:      r = (x << 5) + (x << 1);
      40:      r = (x << 5) + (x << 3);
      45:      r = (x << 5) + (x << 3) + (x << 2) + x;
      47:      r = (x << 5) + (x << 4) - x;
      52:      r = (x << 5) + (x << 4) + (x << 2);
      58:      r = (x << 6) - (x << 2) - (x << 1);
      60:      r = (x << 6) - (x << 2);
      62:      r = (x << 6) - (x << 1);
      63:      r = (x << 6) - x;
      64:      r = x << 6;
      default: r = '0;
    endcase
    return (c < 0) ? -r : r;
  endfunction

  logic                       v1_q, v2_q, v3_q;
  logic                       rdy1, rdy2, rdy3;
  logic [5:0][ACC_W-1:0]      pp_d, pp_q;
  logic signed [ACC_W-1:0]    sa_d, sb_d, sa_q, sb_q;
  logic signed [ACC_W-1:0]    sum_s3;
  logic signed [OUT_W-1:0]    out_d, out_q;

  assign rdy3     = !v3_q || out_ready;
  assign rdy2     = !v2_q || rdy3;
  assign rdy1     = !v1_q || rdy2;
  assign in_ready = rdy1;

  for (genvar gi = 0; gi < 6; gi++) begin : g_tap
    assign pp_d[gi] = mcm(in_samples[gi*SAMPLE_W +: SAMPLE_W], coef_of(in_frac, gi));
  end

  assign sa_d   = $signed(pp_q[0]) + $signed(pp_q[1]) + $signed(pp_q[2]);
  assign sb_d   = $signed(pp_q[3]) + $signed(pp_q[4]) + $signed(pp_q[5]);
  assign sum_s3 = sa_q + sb_q;

  if (SHIFT > 0) begin : g_round
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
    logic signed [ACC_W-1:0] shifted;
    assign shifted = (sum_s3 + RND) >>> SHIFT;
    assign out_d   = shifted[OUT_W-1:0];
  end else begin : g_raw
    assign out_d = sum_s3[OUT_W-1:0];
  end

  // Each stage advances independently so bubbles collapse under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      pp_q  <= '0;
      sa_q  <= '0;
      sb_q  <= '0;
      out_q <= '0;
    end else begin
      if (rdy1) begin
        v1_q <= in_valid;
        if (in_valid) pp_q <= pp_d;
      end
      if (rdy2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sa_q <= sa_d;
          sb_q <= sb_d;
        end
      end
      if (rdy3) begin
        v3_q <= v2_q;
        if (v2_q) out_q <= out_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_affine_luma_interp_6tap.sv
// Directed bench for affine_luma_interp_6tap (default parameters: 8-bit samples, 16-bit out, no shift).
module tb_affine_luma_interp_6tap;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_frac;
  logic [47:0]        in_samples;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  int tests = 0;
  int fails = 0;

  int          rf [10];
  logic [47:0] rs_pk [10];

  // Full 16-position coefficient table written out by hand (positions 9..15 mirrored).
  int coef_tbl [16][6] = '{
    '{0,   0, 64,  0,   0, 0}, '{1,  -3, 63,  4,  -2, 1},
    '{1,  -5, 62,  8,  -3, 1}, '{2,  -8, 60, 13,  -4, 1},
    '{3, -10, 58, 17,  -5, 1}, '{3, -11, 52, 26,  -8, 2},
    '{2,  -9, 47, 31, -10, 3}, '{3, -11, 45, 34, -10, 3},
    '{3, -11, 40, 40, -11, 3}, '{3, -10, 34, 45, -11, 3},
    '{3, -10, 31, 47,  -9, 2}, '{2,  -8, 26, 52, -11, 3},
    '{1,  -5, 17, 58, -10, 3}, '{1,  -4, 13, 60,  -8, 2},
    '{1,  -3,  8, 62,  -5, 1}, '{1,  -2,  4, 63,  -3, 1}
  };

  affine_luma_interp_6tap dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_frac    (in_frac),
    .in_samples (in_samples),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] pack6(input int s0, input int s1, input int s2,
                                        input int s3, input int s4, input int s5);
    return {8'(s5), 8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  function automatic int golden(input int p, input logic [47:0] s);
    int acc = 0;
    for (int k = 0; k < 6; k++) acc += coef_tbl[p][k] * int'(s[k*8 +: 8]);
    return acc;
  endfunction

  // One clock: sample handshake state mid-cycle, then step to just after the next rising edge.
  task automatic tick(output bit acc, output bit xfer, output bit rdy, output logic signed [15:0] d);
    #4;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    rdy  = in_ready;
    d    = out_data;
    @(posedge clk);
    #1;
  endtask

  // Push one group into an empty pipe; lat counts rising edges from the accepting edge until out_valid.
  task automatic run_single(input int p, input logic [47:0] s, output logic signed [15:0] res,
                            output int lat, output bit ok);
    bit acc, xfer, rdy;
    logic signed [15:0] d;
    ok = 1'b0;
    res = '0;
    lat = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_frac    = 4'(p);
    in_samples = s;
    tick(acc, xfer, rdy, d);
    in_valid = 1'b0;
    if (!acc) return;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        res = out_data;
        ok  = 1'b1;
        break;
      end
      tick(acc, xfer, rdy, d);
      lat++;
    end
    tick(acc, xfer, rdy, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_frac = '0;
    in_samples = '0;
    out_ready = 1'b0;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    tests++; if (out_data !== 16'sd0) begin fails++; $display("FAIL reset_out_data actual=%0d required=0", out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready actual=%b required=1", in_ready); end
    $display("[TB] reset: out_valid=%b out_data=%0d in_ready=%b", out_valid, out_data, in_ready);
    @(posedge clk); #1;
  endtask

  task automatic test_integer_pos();
    logic signed [15:0] res; int lat; bit ok;
    run_single(0, pack6(100, 100, 100, 100, 100, 100), res, lat, ok);
    $display("[TB] p=0 flat 100: out=%0d latency=%0d", res, lat);
    tests++; if (!ok) begin fails++; $display("FAIL p0_seen actual=no_output required=output"); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL p0_latency actual=%0d required=3", lat); end
    tests++; if (res !== 16'sd6400) begin fails++; $display("FAIL p0_value actual=%0d required=6400", res); end
  endtask

  task automatic test_half_pel_sign();
    logic signed [15:0] res; int lat; bit ok;
    run_single(8, pack6(0, 0, 255, 255, 0, 0), res, lat, ok);
    $display("[TB] p=8 centre 255: out=%0d", res);
    tests++; if (!ok || res !== 16'sd20400) begin fails++; $display("FAIL p8_pos actual=%0d required=20400", res); end
    run_single(8, pack6(255, 255, 0, 0, 255, 255), res, lat, ok);
    $display("[TB] p=8 outer 255: out=%0d", res);
    tests++; if (!ok || res !== -16'sd4080) begin fails++; $display("FAIL p8_neg actual=%0d required=-4080", res); end
  endtask

  task automatic test_mirror_and_sweep();
    logic signed [15:0] res; int lat; bit ok;
    run_single(5, pack6(10, 20, 30, 40, 50, 60), res, lat, ok);
    $display("[TB] p=5 ramp: out=%0d", res);
    tests++; if (!ok || res !== 16'sd2130) begin fails++; $display("FAIL p5_ramp actual=%0d required=2130", res); end
    run_single(11, pack6(10, 20, 30, 40, 50, 60), res, lat, ok);
    $display("[TB] p=11 ramp: out=%0d", res);
    tests++; if (!ok || res !== 16'sd2350) begin fails++; $display("FAIL p11_ramp actual=%0d required=2350", res); end
    for (int p = 0; p < 16; p++) begin
      run_single(p, pack6(37, 37, 37, 37, 37, 37), res, lat, ok);
      $display("[TB] sweep p=%0d flat 37: out=%0d", p, res);
      tests++; if (!ok || res !== 16'sd2368) begin fails++; $display("FAIL sweep_p%0d actual=%0d required=2368", p, res); end
    end
  endtask

  task automatic test_back_to_back();
    bit acc, xfer, rdy;
    logic signed [15:0] d;
    int sent = 0, recv = 0, cyc = 0, first = -1, last = -1, last_acc = -1;
    for (int i = 0; i < 10; i++) begin
      rf[i] = int'($urandom_range(0, 15));
      rs_pk[i] = pack6(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    out_ready = 1'b1;
    while ((sent < 10 || recv < 10) && cyc < 60) begin
      in_valid = (sent < 10);
      if (sent < 10) begin
        in_frac    = 4'(rf[sent]);
        in_samples = rs_pk[sent];
      end
      tick(acc, xfer, rdy, d);
      if (xfer) begin
        $display("[TB] b2b out #%0d cycle=%0d data=%0d", recv, cyc, d);
        if (recv < 10) begin
          tests++;
          if (d !== 16'(golden(rf[recv], rs_pk[recv]))) begin
            fails++;
            $display("FAIL b2b_data%0d actual=%0d required=%0d", recv, d, golden(rf[recv], rs_pk[recv]));
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        recv++;
      end
      if (acc) begin
        sent++;
        last_acc = cyc;
      end
      cyc++;
    end
    in_valid = 1'b0;
    tests++; if (recv !== 10) begin fails++; $display("FAIL b2b_count actual=%0d required=10", recv); end
    tests++; if (last - first !== 9) begin fails++; $display("FAIL b2b_out_span actual=%0d required=9", last - first); end
    tests++; if (last_acc !== 9) begin fails++; $display("FAIL b2b_in_span actual=%0d required=9", last_acc); end
  endtask

  task automatic test_backpressure();
    bit acc, xfer, rdy;
    logic signed [15:0] d;
    logic signed [15:0] held_d = '0;
    bit stalled = 1'b0;
    int sent = 0, recv = 0, cyc = 0;
    while ((sent < 10 || recv < 10) && cyc < 80) begin
      out_ready = !(cyc >= 4 && cyc <= 9);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        in_frac    = 4'(rf[sent]);
        in_samples = rs_pk[sent];
      end
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== held_d) begin
          fails++;
          $display("FAIL bp_hold_cycle%0d actual=%b/%0d required=1/%0d", cyc, out_valid, out_data, held_d);
        end
      end
      tick(acc, xfer, rdy, d);
      if (cyc >= 4 && cyc <= 9) begin
        tests++;
        if (rdy !== 1'b0) begin fails++; $display("FAIL bp_in_ready_cycle%0d actual=%b required=0", cyc, rdy); end
      end
      stalled = out_valid_sampled(d, held_d);
      if (xfer) begin
        $display("[TB] bp out #%0d cycle=%0d data=%0d", recv, cyc, d);
        if (recv < 10) begin
          tests++;
          if (d !== 16'(golden(rf[recv], rs_pk[recv]))) begin
            fails++;
            $display("FAIL bp_data%0d actual=%0d required=%0d", recv, d, golden(rf[recv], rs_pk[recv]));
          end
        end
        recv++;
      end
      if (acc) sent++;
      if (cyc == 9) begin
        tests++;
        if (sent !== 4) begin fails++; $display("FAIL bp_accepted_during_stall actual=%0d required=4", sent); end
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (recv !== 10) begin fails++; $display("FAIL bp_count actual=%0d required=10", recv); end
  endtask

  // Stall state seen in the last sampled cycle: valid output that was not taken.
  logic bp_last_valid, bp_last_ready;
  always @(negedge clk) begin
    bp_last_valid <= out_valid;
    bp_last_ready <= out_ready;
  end

  function automatic bit out_valid_sampled(input logic signed [15:0] d, output logic signed [15:0] hold);
    hold = d;
    return bp_last_valid && !bp_last_ready;
  endfunction

  task automatic test_reset_midstream();
    bit acc, xfer, rdy;
    logic signed [15:0] d;
    logic signed [15:0] res; int lat; bit ok;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid   = 1'b1;
      in_frac    = 4'(rf[i]);
      in_samples = rs_pk[i];
      tick(acc, xfer, rdy, d);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] mid-stream reset: out_valid=%b out_data=%0d in_ready=%b", out_valid, out_data, in_ready);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid actual=%b required=0", out_valid); end
    tests++; if (out_data !== 16'sd0) begin fails++; $display("FAIL midrst_out_data actual=%0d required=0", out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready actual=%b required=1", in_ready); end
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tick(acc, xfer, rdy, d);
      if (xfer) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_output actual=%0d required=0", seen); end
    run_single(0, pack6(100, 100, 100, 100, 100, 100), res, lat, ok);
    $display("[TB] after reset p=0 flat 100: out=%0d latency=%0d", res, lat);
    tests++; if (!ok || res !== 16'sd6400) begin fails++; $display("FAIL midrst_next_value actual=%0d required=6400", res); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL midrst_next_latency actual=%0d required=3", lat); end
  endtask

  initial begin
    test_reset();
    test_integer_pos();
    test_half_pel_sign();
    test_mirror_and_sweep();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
